// File: rtl/f32sub_pipe.sv
// Three-stage pipelined IEEE-754 binary32 subtractor (x - y) with valid/ready
// handshakes on both sides. Subnormal inputs are read as zero, tiny results
// flush to +0, and rounding is to nearest, ties to even.
module f32sub_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [31:0] CanonNan = 32'h7FC0_0000;

    // ------------------------------------------------------------------
    // Handshake / stage control
    // ------------------------------------------------------------------
    logic v1_q, v2_q, v3_q;
    logic load1, load2, load3;
    logic accept;

    // A stage may load when it is empty or its contents move on this edge.
    assign load3    = !v3_q || out_ready;
    assign load2    = !v2_q || load3;
    assign load1    = !v1_q || load2;
    assign in_ready = rst_n && load1;
    assign accept   = in_valid && in_ready;

    // Stage valid bits; cleared asynchronously so in-flight work is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            if (load1) v1_q <= accept;
            if (load2) v2_q <= v1_q;
            if (load3) v3_q <= v2_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: unpack, classify, order by magnitude, align
    // ------------------------------------------------------------------
    logic        xs, bs;
    logic [7:0]  xe, be;
    logic [22:0] xf, bf;
    logic        x_nan, x_inf, b_nan, b_inf;
    logic [30:0] xk, bk;
    logic [27:0] xm, bm;
    logic        swap;

    // The subtrahend is handled as an addend with its sign inverted.
    assign xs    = x[31];
    assign xe    = x[30:23];
    assign xf    = x[22:0];
    assign bs    = ~y[31];
    assign be    = y[30:23];
    assign bf    = y[22:0];
    assign x_nan = (xe == 8'hFF) && (xf != 23'd0);
    assign x_inf = (xe == 8'hFF) && (xf == 23'd0);
    assign b_nan = (be == 8'hFF) && (bf != 23'd0);
    assign b_inf = (be == 8'hFF) && (bf == 23'd0);
    // Magnitude keys with subnormals collapsed to zero.
    assign xk    = (xe == 8'd0) ? 31'd0 : x[30:0];
    assign bk    = (be == 8'd0) ? 31'd0 : y[30:0];
    // Fraction layout: headroom bit, hidden bit, 23 fraction bits, G/R/S.
    assign xm    = (xe == 8'd0) ? 28'd0 : {2'b01, xf, 3'b000};
    assign bm    = (be == 8'd0) ? 28'd0 : {2'b01, bf, 3'b000};
    assign swap  = bk > xk;

    logic        big_s, sml_s;
    logic [7:0]  big_e, sml_e, shift;
    logic [27:0] big_m, sml_m, aligned, lost_mask;
    logic        s1_special_d;
    logic [31:0] s1_spec_val_d;

    // Put the larger magnitude first and shift the smaller one right, folding
    // every bit shifted out into the sticky position.
    always_comb begin
        big_s     = xs;
        big_e     = xe;
        big_m     = xm;
        sml_s     = bs;
        sml_e     = be;
        sml_m     = bm;
        lost_mask = 28'd0;
        if (swap) begin
            big_s = bs;
            big_e = be;
            big_m = bm;
            sml_s = xs;
            sml_e = xe;
            sml_m = xm;
        end
        shift = big_e - sml_e;
        if (shift >= 8'd28) begin
            aligned = {27'd0, |sml_m};
        end else begin
            lost_mask  = (28'd1 << shift[4:0]) - 28'd1;
            aligned    = sml_m >> shift[4:0];
            aligned[0] = aligned[0] | (|(sml_m & lost_mask));
        end
    end

    // Special operands bypass the datapath with a precomputed result.
    always_comb begin
        s1_special_d  = x_nan || b_nan || x_inf || b_inf;
        s1_spec_val_d = 32'd0;
        if (x_nan || b_nan || (x_inf && b_inf && (xs != bs))) begin
            s1_spec_val_d = CanonNan;
        end else if (x_inf) begin
            s1_spec_val_d = {xs, 8'hFF, 23'd0};
        end else if (b_inf) begin
            s1_spec_val_d = {bs, 8'hFF, 23'd0};
        end
    end

    logic        s1_sign_q, s1_sub_q, s1_special_q;
    logic [7:0]  s1_exp_q;
    logic [27:0] s1_mb_q, s1_ms_q;
    logic [31:0] s1_spec_val_q;

    // Stage 1 data registers, loaded on acceptance.
    always_ff @(posedge clk) begin
        if (load1 && accept) begin
            s1_sign_q     <= big_s;
            s1_sub_q      <= big_s != sml_s;
            s1_exp_q      <= big_e;
            s1_mb_q       <= big_m;
            s1_ms_q       <= aligned;
            s1_special_q  <= s1_special_d;
            s1_spec_val_q <= s1_spec_val_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: signed sum, leading-zero count, normalise
    // ------------------------------------------------------------------
    logic [28:0]        mag;
    logic [4:0]         lz;
    logic [28:0]        norm;
    logic signed [9:0]  exp2;

    // Operands are ordered, so the difference is never negative and the
    // result takes the sign of the larger operand.
    always_comb begin
        if (s1_sub_q) mag = {1'b0, s1_mb_q} - {1'b0, s1_ms_q};
        else          mag = {1'b0, s1_mb_q} + {1'b0, s1_ms_q};
        lz = 5'd0;
        for (int i = 0; i < 29; i++) begin
            if (mag[i]) lz = 5'(28 - i);
        end
        norm = mag << lz;
        // Hidden bit sits at bit 26; after normalising it sits at bit 28.
        exp2 = $signed({2'b00, s1_exp_q}) + 10'sd2 - $signed({5'b00000, lz});
    end

    logic               s2_sign_q, s2_zero_q, s2_special_q;
    logic signed [9:0]  s2_exp_q;
    logic [28:0]        s2_norm_q;
    logic [31:0]        s2_spec_val_q;

    // Stage 2 data registers.
    always_ff @(posedge clk) begin
        if (load2 && v1_q) begin
            s2_sign_q     <= s1_sign_q;
            s2_zero_q     <= mag == 29'd0;
            s2_exp_q      <= exp2;
            s2_norm_q     <= norm;
            s2_special_q  <= s1_special_q;
            s2_spec_val_q <= s1_spec_val_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: round to nearest even, range check, pack
    // ------------------------------------------------------------------
    logic               guard, sticky, round_up;
    logic [24:0]        m25;
    logic signed [9:0]  exp3;
    logic [22:0]        frac3;
    logic [31:0]        res3;

    // A rounding carry renormalises to 1.0 and bumps the exponent.
    always_comb begin
        guard    = s2_norm_q[4];
        sticky   = |s2_norm_q[3:0];
        round_up = guard && (sticky || s2_norm_q[5]);
        m25      = {1'b0, s2_norm_q[28:5]} + {24'd0, round_up};
        exp3     = m25[24] ? s2_exp_q + 10'sd1 : s2_exp_q;
        frac3    = m25[24] ? m25[23:1] : m25[22:0];
        if (s2_special_q) begin
            res3 = s2_spec_val_q;
        end else if (s2_zero_q) begin
            res3 = 32'd0;
        end else if (exp3 >= 10'sd255) begin
            res3 = {s2_sign_q, 8'hFF, 23'd0};
        end else if (exp3 <= 10'sd0) begin
            res3 = 32'd0;
        end else begin
            res3 = {s2_sign_q, exp3[7:0], frac3};
        end
    end

    logic [31:0] s3_res_q;

    // Stage 3 result register.
    always_ff @(posedge clk) begin
        if (load3 && v2_q) s3_res_q <= res3;
    end

    assign out_valid = v3_q;
    assign out       = v3_q ? s3_res_q : 32'd0;

endmodule

// File: tb/tb_f32sub_pipe.sv
// Self-checking bench for f32sub_pipe: directed vector table, hand-written
// backpressure and reset sequences, and a randomized stream scored against a
// real-arithmetic reference model.
module tb_f32sub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] x = 32'd0;
    logic [31:0] y = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    f32sub_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .y         (y),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, got, want);
        end
    endtask

    // binary32 -> real, subnormals read as zero
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Reference: exact real difference, then round to 24 bits (ties even)
    // with unbounded exponent, then apply overflow / flush rules.
    function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
        logic        sb, a_nan, b_nan, a_inf, b_inf, up;
        logic [63:0] bits;
        logic [52:0] mant;
        logic [24:0] m;
        real         d;
        int          e;
        sb    = ~b[31];
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (a_nan || b_nan) return 32'h7FC0_0000;
        if (a_inf && b_inf) return (a[31] != sb) ? 32'h7FC0_0000 : {a[31], 8'hFF, 23'd0};
        if (a_inf) return {a[31], 8'hFF, 23'd0};
        if (b_inf) return {sb, 8'hFF, 23'd0};
        d = f2r(a) - f2r(b);
        if (d == 0.0) return 32'd0;
        bits = $realtobits(d);
        e    = int'(bits[62:52]) - 1023;
        mant = {1'b1, bits[51:0]};
        m    = {1'b0, mant[52:29]};
        up   = mant[28] && ((|mant[27:0]) || mant[29]);
        m    = m + {24'd0, up};
        if (m[24]) begin
            e++;
            m = m >> 1;
        end
        e = e + 127;
        if (e >= 255) return {bits[63], 8'hFF, 23'd0};
        if (e <= 0) return 32'd0;
        return {bits[63], 8'(e), m[22:0]};
    endfunction

    task automatic rand_pair(output logic [31:0] a, output logic [31:0] b);
        logic [31:0] sp [6];
        int          mode;
        int          e;
        sp   = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                 32'h7FC0_0000, 32'h0001_2345};
        mode = int'($urandom_range(0, 9));
        a    = $urandom;
        b    = $urandom;
        case (mode)
            0: ;
            1: begin
                a = sp[$urandom_range(0, 5)];
                if ($urandom_range(0, 1) == 0) b = sp[$urandom_range(0, 5)];
            end
            2, 3: begin
                // near-total cancellation
                b       = a ^ {24'd0, 8'($urandom_range(0, 255))};
                b[31]   = a[31];
            end
            default: begin
                a[30:23] = 8'($urandom_range(1, 254));
                e = int'(a[30:23]) + int'($urandom_range(0, 8)) - 4;
                if (e < 1) e = 1;
                if (e > 254) e = 254;
                b[30:23] = 8'(e);
            end
        endcase
    endtask

    vec_t        tv[$];
    logic [31:0] q[$];
    logic [31:0] ra, rb, got, prev_out;
    logic [31:0] exp_seq [3];
    int          seen, occ, sent, got_n, stale;
    bit          prev_hold;
    localparam int NumRand = 300;

    initial begin
        tv.push_back('{32'h4040_0000, 32'h3F80_0000, 32'h4000_0000});
        tv.push_back('{32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000});
        tv.push_back('{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000});
        tv.push_back('{32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000});
        tv.push_back('{32'h7F80_0000, 32'hFF80_0000, 32'h7F80_0000});
        tv.push_back('{32'h7FC0_0001, 32'h1234_5678, 32'h7FC0_0000});
        tv.push_back('{32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000});
        tv.push_back('{32'h0080_0001, 32'h0080_0000, 32'h0000_0000});
        tv.push_back('{32'h4B80_0001, 32'hBF80_0000, 32'h4B80_0002});
        tv.push_back('{32'h4B80_0000, 32'hBF80_0000, 32'h4B80_0000});
        tv.push_back('{32'h0000_0000, 32'h0000_0000, 32'h0000_0000});
        tv.push_back('{32'h8000_0000, 32'h8000_0000, 32'h0000_0000});
        tv.push_back('{32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000});
        tv.push_back('{32'h0040_0000, 32'h3F80_0000, 32'hBF80_0000});
        tv.push_back('{32'h3F80_0000, 32'h0000_0001, 32'h3F80_0000});
        tv.push_back('{32'h3FC0_0000, 32'h3F80_0000, 32'h3F00_0000});
        tv.push_back('{32'h4F00_0000, 32'h3F80_0000, 32'h4F00_0000});

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out", out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors: value and latency
        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            x = tv[i].a;
            y = tv[i].b;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            check($sformatf("vec%0d_accept", i), 32'(in_ready), 32'd1);
            seen = -1;
            got  = 32'hDEAD_BEEF;
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
                if (out_valid && seen < 0) begin
                    seen = c;
                    got  = out;
                end
            end
            check($sformatf("vec%0d_latency", i), 32'(seen), 32'd3);
            check($sformatf("vec%0d_value", i), got, tv[i].exp);
        end

        // Backpressure: fill with out_ready low, check stall and hold, then drain
        exp_seq = '{32'h4000_0000, 32'h4000_0000, 32'h4B80_0002};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            x = (c == 2) ? 32'h4B80_0001 : ((c == 1) ? 32'h3F80_0000 : 32'h4040_0000);
            y = (c == 2) ? 32'hBF80_0000 : ((c == 1) ? 32'hBF80_0000 : 32'h3F80_0000);
            #1;
            check($sformatf("fill_in_ready%0d", c), 32'(in_ready), (c < 3) ? 32'd1 : 32'd0);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check($sformatf("hold_valid%0d", c), 32'(out_valid), 32'd1);
            check($sformatf("hold_out%0d", c), out, exp_seq[0]);
        end
        got_n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                if (got_n < 3) check($sformatf("drain%0d", got_n), out, exp_seq[got_n]);
                got_n++;
            end
        end
        check("drain_count", 32'(got_n), 32'd3);

        // Randomized stream with random backpressure
        occ = 0;
        sent = 0;
        got_n = 0;
        prev_hold = 1'b0;
        prev_out = 32'd0;
        for (int cyc = 0; cyc < 5000 && got_n < NumRand; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 2) != 0);
            if (sent < NumRand && $urandom_range(0, 3) != 0) begin
                rand_pair(ra, rb);
                x = ra;
                y = rb;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("rand_in_ready", 32'(in_ready), (occ < 3 || out_ready) ? 32'd1 : 32'd0);
            if (prev_hold) begin
                check("rand_hold_valid", 32'(out_valid), 32'd1);
                check("rand_hold_out", out, prev_out);
            end
            if (!out_valid) check("rand_idle_out", out, 32'd0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rand_extra_result", out, 32'hFFFF_FFFF ^ out);
                end else begin
                    check("rand_result", out, q.pop_front());
                end
                got_n++;
                occ--;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_sub(x, y));
                sent++;
                occ++;
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = out;
        end
        check("rand_delivered", 32'(got_n), 32'(NumRand));

        // Reset with three operations in flight
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            x = 32'h4040_0000;
            y = 32'h3F80_0000;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("inflight_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out", out, 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            if (out_valid) stale++;
        end
        check("no_stale_after_rst", 32'(stale), 32'd0);
        check("rel_in_ready", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
